// File: rtl/stage_execute.sv
`default_nettype none
// ============================================================================
// stage_execute : operand forwarding, ALU, branch resolution, EX->MEM register
// Optional forwarding muxes enabled by defining STAGE_EXECUTE_FORWARD_EN.
// Revision: 1.0
// ============================================================================
module stage_execute #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mem_clear,
   input  logic            mem_hold,
   input  logic            ex_reg_write,
   input  logic            ex_mem_write,
   input  logic            ex_jump,
   input  logic            ex_jump_cond,
   input  logic            ex_alu_src,
   input  logic [2:0]      ex_jump_cond_type,
   input  logic [2:0]      ex_alu_control,
   input  logic [1:0]      ex_result_src,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_pc_plus_4,
   input  logic [XLEN-1:0] ex_imm_ext,
   input  logic [XLEN-1:0] ex_rd1,
   input  logic [XLEN-1:0] ex_rd2,
   input  logic [4:0]      ex_rd,
   input  logic [4:0]      ex_rs1,
   input  logic [4:0]      ex_rs2,
   input  logic [1:0]      ex_forward_a,
   input  logic [1:0]      ex_forward_b,
   input  logic [XLEN-1:0] wb_result,
   output logic            ex_pc_src,
   output logic [XLEN-1:0] ex_pc_target,
   output logic [4:0]      ex_rs1_haz,
   output logic [4:0]      ex_rs2_haz,
   output logic [4:0]      ex_rd_haz,
   output logic            mem_reg_write,
   output logic            mem_mem_write,
   output logic [1:0]      mem_result_src,
   output logic [XLEN-1:0] mem_alu_result,
   output logic [XLEN-1:0] mem_write_data,
   output logic [XLEN-1:0] mem_pc_plus_4,
   output logic [4:0]      mem_rd
);

   logic [XLEN-1:0] src_a, write_data, src_b, alu_result;
   logic            cond_true;

   logic            mem_reg_write_q, mem_reg_write_d;
   logic            mem_mem_write_q, mem_mem_write_d;
   logic [1:0]      mem_result_src_q, mem_result_src_d;
   logic [XLEN-1:0] mem_alu_result_q, mem_alu_result_d;
   logic [XLEN-1:0] mem_write_data_q, mem_write_data_d;
   logic [XLEN-1:0] mem_pc_plus_4_q, mem_pc_plus_4_d;
   logic [4:0]      mem_rd_q, mem_rd_d;

`ifdef STAGE_EXECUTE_FORWARD_EN
   // Select 11 is unused by the hazard unit and falls back to the register file.
   always_comb begin
      case (ex_forward_a)
         2'b01:   src_a = wb_result;
         2'b10:   src_a = mem_alu_result_q;
         default: src_a = ex_rd1;
      endcase
      case (ex_forward_b)
         2'b01:   write_data = wb_result;
         2'b10:   write_data = mem_alu_result_q;
         default: write_data = ex_rd2;
      endcase
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{ex_forward_a, ex_forward_b, wb_result};

   always_comb begin
      src_a      = ex_rd1;
      write_data = ex_rd2;
   end
`endif

   assign src_b = ex_alu_src ? ex_imm_ext : write_data;

   always_comb begin
      case (ex_alu_control)
         3'b000:  alu_result = src_a + src_b;
         3'b001:  alu_result = src_a - src_b;
         3'b010:  alu_result = src_a & src_b;
         3'b011:  alu_result = src_a | src_b;
         3'b100:  alu_result = src_a ^ src_b;
         3'b101:  alu_result = src_a << src_b[4:0];
         3'b110:  alu_result = src_a >> src_b[4:0];
         default: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      endcase
   end

   // Branches compare against the forwarded rs2 value, never the immediate.
   always_comb begin
      case (ex_jump_cond_type)
         3'b000:  cond_true = (src_a == write_data);
         3'b001:  cond_true = (src_a != write_data);
         3'b100:  cond_true = ($signed(src_a) <  $signed(write_data));
         3'b101:  cond_true = ($signed(src_a) >= $signed(write_data));
         3'b110:  cond_true = (src_a <  write_data);
         3'b111:  cond_true = (src_a >= write_data);
         default: cond_true = 1'b0;
      endcase
   end

   assign ex_pc_src    = ex_jump | (ex_jump_cond & cond_true);
   assign ex_pc_target = ex_pc + ex_imm_ext;
   assign ex_rs1_haz   = ex_rs1;
   assign ex_rs2_haz   = ex_rs2;
   assign ex_rd_haz    = ex_rd;

   always_comb begin
      mem_reg_write_d  = mem_reg_write_q;
      mem_mem_write_d  = mem_mem_write_q;
      mem_result_src_d = mem_result_src_q;
      mem_alu_result_d = mem_alu_result_q;
      mem_write_data_d = mem_write_data_q;
      mem_pc_plus_4_d  = mem_pc_plus_4_q;
      mem_rd_d         = mem_rd_q;
      if (mem_clear) begin
         mem_reg_write_d  = 1'b0;
         mem_mem_write_d  = 1'b0;
         mem_result_src_d = '0;
         mem_alu_result_d = '0;
         mem_write_data_d = '0;
         mem_pc_plus_4_d  = '0;
         mem_rd_d         = '0;
      end else if (!mem_hold) begin
         mem_reg_write_d  = ex_reg_write;
         mem_mem_write_d  = ex_mem_write;
         mem_result_src_d = ex_result_src;
         mem_alu_result_d = alu_result;
         mem_write_data_d = write_data;
         mem_pc_plus_4_d  = ex_pc_plus_4;
         mem_rd_d         = ex_rd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_reg_write_q  <= 1'b0;
         mem_mem_write_q  <= 1'b0;
         mem_result_src_q <= '0;
         mem_alu_result_q <= '0;
         mem_write_data_q <= '0;
         mem_pc_plus_4_q  <= '0;
         mem_rd_q         <= '0;
      end else begin
         mem_reg_write_q  <= mem_reg_write_d;
         mem_mem_write_q  <= mem_mem_write_d;
         mem_result_src_q <= mem_result_src_d;
         mem_alu_result_q <= mem_alu_result_d;
         mem_write_data_q <= mem_write_data_d;
         mem_pc_plus_4_q  <= mem_pc_plus_4_d;
         mem_rd_q         <= mem_rd_d;
      end
   end

   assign mem_reg_write  = mem_reg_write_q;
   assign mem_mem_write  = mem_mem_write_q;
   assign mem_result_src = mem_result_src_q;
   assign mem_alu_result = mem_alu_result_q;
   assign mem_write_data = mem_write_data_q;
   assign mem_pc_plus_4  = mem_pc_plus_4_q;
   assign mem_rd         = mem_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_execute.sv
`default_nettype none
// ============================================================================
// tb_stage_execute : scoreboard bench with a reference model of the execute stage
// Revision: 1.0
// ============================================================================
module tb_stage_execute;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        mem_clear = 1'b0, mem_hold = 1'b0;
   logic        ex_reg_write = 1'b0, ex_mem_write = 1'b0, ex_jump = 1'b0;
   logic        ex_jump_cond = 1'b0, ex_alu_src = 1'b0;
   logic [2:0]  ex_jump_cond_type = '0, ex_alu_control = '0;
   logic [1:0]  ex_result_src = '0, ex_forward_a = '0, ex_forward_b = '0;
   logic [31:0] ex_pc = '0, ex_pc_plus_4 = '0, ex_imm_ext = '0;
   logic [31:0] ex_rd1 = '0, ex_rd2 = '0, wb_result = '0;
   logic [4:0]  ex_rd = '0, ex_rs1 = '0, ex_rs2 = '0;
   logic        ex_pc_src;
   logic [31:0] ex_pc_target;
   logic [4:0]  ex_rs1_haz, ex_rs2_haz, ex_rd_haz;
   logic        mem_reg_write, mem_mem_write;
   logic [1:0]  mem_result_src;
   logic [31:0] mem_alu_result, mem_write_data, mem_pc_plus_4;
   logic [4:0]  mem_rd;

   stage_execute #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .mem_clear(mem_clear), .mem_hold(mem_hold),
      .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write), .ex_jump(ex_jump),
      .ex_jump_cond(ex_jump_cond), .ex_alu_src(ex_alu_src),
      .ex_jump_cond_type(ex_jump_cond_type), .ex_alu_control(ex_alu_control),
      .ex_result_src(ex_result_src), .ex_pc(ex_pc), .ex_pc_plus_4(ex_pc_plus_4),
      .ex_imm_ext(ex_imm_ext), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_rd(ex_rd),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_forward_a(ex_forward_a),
      .ex_forward_b(ex_forward_b), .wb_result(wb_result), .ex_pc_src(ex_pc_src),
      .ex_pc_target(ex_pc_target), .ex_rs1_haz(ex_rs1_haz), .ex_rs2_haz(ex_rs2_haz),
      .ex_rd_haz(ex_rd_haz), .mem_reg_write(mem_reg_write),
      .mem_mem_write(mem_mem_write), .mem_result_src(mem_result_src),
      .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
      .mem_pc_plus_4(mem_pc_plus_4), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rw;
      logic        mw;
      logic [1:0]  rs;
      logic [31:0] alu;
      logic [31:0] wd;
      logic [31:0] pc4;
      logic [4:0]  rd;
   } reg_t;

   typedef struct {
      int    due;
      reg_t  r;
   } reg_item_t;

   typedef struct {
      int          due;
      logic        pc_src;
      logic [31:0] target;
      logic [14:0] haz;
   } comb_item_t;

   reg_item_t  qr[$];
   comb_item_t qc[$];
   reg_t       m = '0;
   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf);
`ifdef STAGE_EXECUTE_FORWARD_EN
      if (sel == 2'b01) return wb_result;
      if (sel == 2'b10) return m.alu;
`endif
      return rf;
   endfunction

   function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      int sh;
      sh = int'(b % 32);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return a << sh;
         3'd6: return a >> sh;
         default: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      endcase
   endfunction

   function automatic logic cond_ref(input logic [2:0] t, input logic [31:0] a,
                                     input logic [31:0] b);
      case (t)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return int'(a) < int'(b);
         3'd5: return int'(a) >= int'(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   // Record expectations for the inputs currently applied, then advance the model.
   task automatic issue(input logic clr, input logic hld);
      logic [31:0] a, wd, b;
      comb_item_t  ci;
      reg_item_t   ri;
      reg_t        ld;
      mem_clear = clr;
      mem_hold  = hld;
      a  = fwd(ex_forward_a, ex_rd1);
      wd = fwd(ex_forward_b, ex_rd2);
      b  = ex_alu_src ? ex_imm_ext : wd;
      ci.due    = cyc;
      ci.pc_src = ex_jump || (ex_jump_cond && cond_ref(ex_jump_cond_type, a, wd));
      ci.target = ex_pc + ex_imm_ext;
      ci.haz    = {ex_rs1, ex_rs2, ex_rd};
      qc.push_back(ci);
      ld = '{rw: ex_reg_write, mw: ex_mem_write, rs: ex_result_src,
             alu: alu_ref(ex_alu_control, a, b), wd: wd, pc4: ex_pc_plus_4, rd: ex_rd};
      if (clr) m = '0;
      else if (!hld) m = ld;
      ri.due = cyc + 1;
      ri.r   = m;
      qr.push_back(ri);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic randomize_inputs();
      ex_reg_write      = 1'($urandom);
      ex_mem_write      = 1'($urandom);
      ex_jump           = ($urandom_range(0, 7) == 0);
      ex_jump_cond      = 1'($urandom);
      ex_alu_src        = 1'($urandom);
      ex_jump_cond_type = 3'($urandom);
      ex_alu_control    = 3'($urandom);
      ex_result_src     = 2'($urandom);
      ex_pc             = $urandom;
      ex_pc_plus_4      = $urandom;
      ex_imm_ext        = $urandom;
      ex_rd1            = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      ex_rd2            = ($urandom_range(0, 3) == 0) ? ex_rd1 : $urandom;
      ex_rd             = 5'($urandom);
      ex_rs1            = 5'($urandom);
      ex_rs2            = 5'($urandom);
      ex_forward_a      = 2'($urandom);
      ex_forward_b      = 2'($urandom);
      wb_result         = $urandom;
   endtask

   task automatic set_op(input logic [2:0] op, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] imm, input logic asrc);
      ex_alu_control = op;   ex_rd1 = r1;          ex_rd2 = r2;
      ex_imm_ext = imm;      ex_alu_src = asrc;    ex_jump = 1'b0;
      ex_jump_cond = 1'b0;   ex_forward_a = 2'b00; ex_forward_b = 2'b00;
      ex_reg_write = 1'b1;   ex_mem_write = 1'b0;  ex_result_src = 2'b00;
      ex_rd = 5'd3;          ex_rs1 = 5'd1;        ex_rs2 = 5'd2;
      ex_pc = 32'h100;       ex_pc_plus_4 = 32'h104;
   endtask

   function automatic logic [104:0] dut_regs();
      return {mem_reg_write, mem_mem_write, mem_result_src, mem_alu_result,
              mem_write_data, mem_pc_plus_4, mem_rd};
   endfunction

   // Monitor: compares every expectation once the DUT is due to present it.
   initial begin
      comb_item_t ci;
      reg_item_t  ri;
      forever begin
         @(negedge clk);
         while (qc.size() > 0 && qc[0].due <= cyc) begin
            ci = qc.pop_front();
            check("pc_src", 128'(ex_pc_src), 128'(ci.pc_src));
            check("pc_target", 128'(ex_pc_target), 128'(ci.target));
            check("haz_idx", 128'({ex_rs1_haz, ex_rs2_haz, ex_rd_haz}), 128'(ci.haz));
         end
         while (qr.size() > 0 && qr[0].due <= cyc) begin
            ri = qr.pop_front();
            check("mem_regs", 128'(dut_regs()), 128'(ri.r));
         end
      end
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      randomize_inputs();
      #1 rst_n = 1'b0;
      #1 check("reset_async", 128'(dut_regs()), 128'(0));
      next_cycle();
      check("reset_held", 128'(dut_regs()), 128'(0));
      rst_n = 1'b1;

      set_op(3'd0, 32'd5, 32'd7, 32'd0, 1'b0);              issue(0, 0);
      next_cycle(); set_op(3'd0, 32'h10, 32'd0, 32'd0, 1'b0); issue(0, 0);
      next_cycle(); set_op(3'd0, 32'd1, 32'd0, 32'd4, 1'b1);
      ex_forward_a = 2'b10;                                 issue(0, 0);
      next_cycle(); set_op(3'd0, 32'd1, 32'd0, 32'd4, 1'b1);
      ex_forward_a = 2'b01; wb_result = 32'h20;             issue(0, 0);
      next_cycle(); set_op(3'd0, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0);
      ex_jump_cond = 1'b1; ex_jump_cond_type = 3'b100;      issue(0, 0);
      next_cycle(); set_op(3'd0, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0);
      ex_jump_cond = 1'b1; ex_jump_cond_type = 3'b110;      issue(0, 0);
      next_cycle(); set_op(3'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0); issue(0, 0);
      next_cycle(); set_op(3'd5, 32'd1, 32'd33, 32'd0, 1'b0);        issue(0, 0);
      next_cycle(); set_op(3'd7, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0); issue(0, 0);
      next_cycle(); set_op(3'd1, 32'd0, 32'd1, 32'd0, 1'b0);         issue(0, 0);
      for (int i = 0; i < 3; i++) begin
         next_cycle(); randomize_inputs(); issue(0, 1);
      end
      next_cycle(); randomize_inputs(); issue(0, 0);
      next_cycle(); randomize_inputs(); issue(1, 1);
      next_cycle(); randomize_inputs(); issue(0, 0);
      next_cycle(); randomize_inputs(); issue(0, 1);

      // Reset in the middle of a hold: the register must clear without an edge.
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 check("reset_mid_hold", 128'(dut_regs()), 128'(0));
      m = '0;
      qr.delete();
      next_cycle(); randomize_inputs(); mem_hold = 1'b1;
      next_cycle();
      check("reset_after_edge", 128'(dut_regs()), 128'(0));
      rst_n = 1'b1;
      randomize_inputs(); issue(0, 0);

      for (int i = 0; i < 300; i++) begin
         next_cycle();
         randomize_inputs();
         issue(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
      end

      repeat (3) next_cycle();
      check("queue_drained", 128'(qr.size() + qc.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
